// File: rtl/mrr_decode_path_arbiter.sv
// Per-pathway word FIFO: stores {tlast, tdata} for one decode pathway.
// Latency: a word written on cycle N is visible at the head on cycle N+1.
// Backpressure: a push is refused while full, even if a pop happens in the same cycle.
module mrr_decode_fifo #(
  parameter int W   = 33,
  parameter int DL2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int DEPTH = 1 << DL2;

  logic [W-1:0] r_mem [DEPTH];
  logic [DL2:0] r_wr;
  logic [DL2:0] r_rd;
  logic [DL2:0] w_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_cnt   = r_wr - r_rd;
  assign o_empty = (w_cnt == '0);
  assign o_full  = (w_cnt == (DL2+1)'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd[DL2-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[DL2-1:0]] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// Merges N decode pathways into one stream with packet-atomic round-robin and a per-packet header.
// Latency: a word pushed into an idle arbiter on cycle N gives header valid on N+2, first body beat at N+3.
// Backpressure: each pathway stalls only on its own full FIFO; o_tready=0 holds the current beat stable.
module mrr_decode_path_arbiter #(
  parameter int          NUM_PATHWAYS    = 4,
  parameter int          DATA_WIDTH      = 32,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter int          MAX_PKT_WORDS   = 255,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PATHWAYS-1:0]            enable_mask,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic                               o_tvalid,
  output logic                               o_tlast,
  input  logic                               o_tready,
  output logic [7:0]                         o_grant_idx,
  output logic                               o_busy,
  output logic [15:0]                        pkt_count,
  output logic [15:0]                        trunc_count
);
  localparam int IW = (NUM_PATHWAYS > 1) ? $clog2(NUM_PATHWAYS) : 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_grant;
  logic [IW-1:0]           r_rr;
  logic [15:0]             r_seq [NUM_PATHWAYS];
  logic [CW-1:0]           r_body_cnt;
  logic [15:0]             r_pkt_cnt;
  logic [15:0]             r_trunc_cnt;
  logic [DATA_WIDTH:0]     w_head [NUM_PATHWAYS];
  logic [NUM_PATHWAYS-1:0] w_empty;
  logic [NUM_PATHWAYS-1:0] w_full;
  logic [NUM_PATHWAYS-1:0] w_pop;
  logic [IW:0]             w_sum;
  logic [IW-1:0]           w_cand;
  logic                    w_cand_vld;
  logic                    w_g_empty;
  logic                    w_g_last;
  logic                    w_at_max;
  logic                    w_beat;
  logic                    w_drain_pop;

  for (genvar p = 0; p < NUM_PATHWAYS; p++) begin : g_path
    mrr_decode_fifo #(.W(DATA_WIDTH + 1), .DL2(FIFO_DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_tvalid[p]),
      .i_dat   ({i_tlast[p], i_tdata[DATA_WIDTH*(p+1)-1 -: DATA_WIDTH]}),
      .i_pop   (w_pop[p]),
      .o_dat   (w_head[p]),
      .o_empty (w_empty[p]),
      .o_full  (w_full[p])
    );
    assign w_pop[p] = (r_grant == IW'(p)) && (w_beat || w_drain_pop);
  end

  assign i_tready    = ~w_full;
  assign w_g_empty   = w_empty[r_grant];
  assign w_g_last    = w_head[r_grant][DATA_WIDTH];
  assign w_at_max    = (r_body_cnt == CW'(MAX_PKT_WORDS - 1));
  assign w_beat      = (r_state == S_BODY) && !w_g_empty && o_tready;
  assign w_drain_pop = (r_state == S_DRAIN) && !w_g_empty;
  assign o_grant_idx = 8'(r_grant);
  assign pkt_count   = r_pkt_cnt;
  assign trunc_count = r_trunc_cnt;

  // Descending scan so the lowest offset from the RR pointer wins.
  always_comb begin
    w_cand     = '0;
    w_cand_vld = 1'b0;
    w_sum      = '0;
    for (int i = NUM_PATHWAYS - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_PATHWAYS)) w_sum = w_sum - (IW+1)'(NUM_PATHWAYS);
      if (!w_empty[w_sum[IW-1:0]] && enable_mask[w_sum[IW-1:0]]) begin
        w_cand     = w_sum[IW-1:0];
        w_cand_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cand_vld) w_state_nxt = S_HEADER;
      S_HEADER: if (o_tready) w_state_nxt = S_BODY;
      S_BODY: begin
        if (w_beat && w_g_last)      w_state_nxt = S_IDLE;
        else if (w_beat && w_at_max) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (w_drain_pop && w_g_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    o_busy   = (r_state != S_IDLE);
    case (r_state)
      S_HEADER: begin
        o_tvalid = 1'b1;
        o_tdata  = DATA_WIDTH'({SYNC_BYTE, 8'(r_grant), r_seq[r_grant]});
      end
      S_BODY: begin
        o_tvalid = !w_g_empty;
        o_tdata  = w_head[r_grant][DATA_WIDTH-1:0];
        o_tlast  = !w_g_empty && (w_g_last || w_at_max);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant     <= '0;
      r_rr        <= '0;
      r_body_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_trunc_cnt <= '0;
      for (int p = 0; p < NUM_PATHWAYS; p++) r_seq[p] <= '0;
    end else begin
      if (r_state == S_IDLE && w_cand_vld) r_grant <= w_cand;
      if (r_state == S_HEADER && o_tready) begin
        r_seq[r_grant] <= r_seq[r_grant] + 16'd1;
        r_pkt_cnt      <= r_pkt_cnt + 16'd1;
        r_body_cnt     <= '0;
      end
      if (w_beat) begin
        r_body_cnt <= r_body_cnt + 1'b1;
        if (!w_g_last && w_at_max) r_trunc_cnt <= r_trunc_cnt + 16'd1;
      end
      if ((w_beat || w_drain_pop) && w_g_last)
        r_rr <= (r_grant == IW'(NUM_PATHWAYS - 1)) ? '0 : r_grant + 1'b1;
    end
  end
endmodule

// File: doc/mrr_decode_path_arbiter.md
Name: mrr_decode_path_arbiter

Overview:
- Parametrised N-pathway merger for the decoded-word streams produced by the per-pathway loopback/decode instances in the MRR gateway.
- Replaces the shared, unarbitrated output drive with a per-pathway FIFO and a packet-atomic round-robin arbiter.
- Each forwarded packet gets a header word carrying pathway index and per-pathway sequence number; runaway packets are truncated and their tails dropped.

Parameters:
- NUM_PATHWAYS, 4, number of decode pathways; range 1..256.
- DATA_WIDTH, 32, word width; must be >=32.
- FIFO_DEPTH_LOG2, 4, log2 of per-pathway FIFO depth in words.
- MAX_PKT_WORDS, 255, maximum body words per packet before forced truncation; must be >=1.
- SYNC_BYTE, 8'hA5, constant in header bits [31:24].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable_mask  in  NUM_PATHWAYS  per-pathway grant enable.
- i_tdata  in  DATA_WIDTH*NUM_PATHWAYS  packed pathway data; pathway p occupies [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH].
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tlast  in  NUM_PATHWAYS  per-pathway end of packet.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- o_tdata  out  DATA_WIDTH  merged stream data.
- o_tvalid  out  1  merged stream valid.
- o_tlast  out  1  merged stream end of packet.
- o_tready  in  1  downstream ready.
- o_grant_idx  out  8  pathway currently granted.
- o_busy  out  1  high in any state other than IDLE.
- pkt_count  out  16  packets forwarded (headers accepted); wraps.
- trunc_count  out  16  packets truncated; wraps.

Behaviour:
- Reset (rst=0): all FIFOs empty, state IDLE, RR pointer 0, all sequence numbers 0. Outputs: o_tvalid=0, o_tlast=0, o_tdata=0, o_grant_idx=0, o_busy=0, counters=0, i_tready=all 1. Reset mid-packet discards everything in flight; no partial packet resumes after reset.
- FIFO (one per pathway):
  - i_tready[p] = !full[p]; no push when full, even if a pop occurs in the same cycle.
  - Stores {tlast, tdata}. A word written on cycle N is visible as non-empty on N+1.
  - Simultaneous push and pop when not full keeps occupancy constant.
- Arbiter, IDLE:
  - Candidates are pathways with non-empty FIFO and enable_mask[p]=1.
  - Search starts at the RR pointer, ascending with wrap. Grant the first candidate g, latch o_grant_idx=g, go to HEADER.
  - enable_mask is sampled only in IDLE. Clearing a bit mid-packet does not abort the packet; data keeps queuing in that pathway's FIFO.
- HEADER:
  - o_tvalid=1, o_tlast=0, o_tdata = {zero pad, SYNC_BYTE, g[7:0], seq[g][15:0]}.
  - On o_tready: seq[g]++ (16-bit wrap), pkt_count++, body word count cleared, go to BODY.
- BODY:
  - o_tvalid = !empty[g]; o_tdata is the FIFO head; the FIFO pops on o_tvalid & o_tready.
  - An empty FIFO mid-packet stalls the output (o_tvalid=0); the grant is held.
  - Popped word with tlast=1: o_tlast=1 on that beat, then RR pointer = g+1 (mod NUM_PATHWAYS), go to IDLE.
  - Popped word without tlast that is body word MAX_PKT_WORDS: forced o_tlast=1 on that beat, trunc_count++, go to DRAIN.
  - If that word carries tlast, there is no truncation; it follows the normal end-of-packet path.
- DRAIN:
  - o_tvalid=0. Pop FIFO g every cycle it is non-empty and discard.
  - When a word with tlast is popped: RR pointer = g+1, go to IDLE.
- Latency: a word pushed into an idle arbiter on cycle N gives header valid on N+2 and the first body beat at the earliest on N+3. IDLE costs one dead cycle between packets.
- Output stability: o_tdata and o_tlast hold while o_tvalid=1 and o_tready=0.
- Counters: 16-bit, wrap 0xFFFF->0.

Test Plan:
- Single pathway 1, 3-word packet {0x11,0x22,0x33/tlast}, o_tready=1 -> beats 0xA5010000, 0x11, 0x22, 0x33 with tlast; pkt_count=1; second packet header 0xA5010001.
- Pathways 0 and 2 each loaded with two 2-word packets simultaneously -> order 0,2,0,2, each with an atomic header+2 beats; seq for each pathway goes 0 then 1.
- Pathway 3 sends 300 words, MAX_PKT_WORDS=255 -> 256 beats out (header+255), beat 256 with tlast; trunc_count=1; remaining 45 words dropped; o_tvalid=0 during DRAIN; next packet forwarded normally.
- o_tready toggled 1010... and FIFO depth 16 filled with 20 words -> i_tready[p]=0 while full, no loss or duplication, o_tdata stable while stalled.
- enable_mask=4'b1011 with pathway 2 loaded -> never granted; setting bit 2 -> granted at next IDLE. Clearing bit 0 mid-packet -> packet completes.
- rst asserted mid-BODY -> o_tvalid=0 and all counters 0 immediately; after release, a new packet gets header seq 0.
